// File: rtl/reservoir_sched_if.sv
// Request/grant/volume bundle between client request logic and reservoir_sched.
interface reservoir_sched_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CBITS = 14,
  parameter int unsigned AW    = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    dir;
  logic [NREQ*AW-1:0] amt;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               trunc;
  logic               busy;
  logic [CBITS-1:0]   vol;
  logic               full;
  logic               empty;

  // Client side: issues requests, observes grants, completion and volume.
  modport master (
    output req, dir, amt,
    input  gnt, done, trunc, busy, vol, full, empty
  );

  // Scheduler side.
  modport slave (
    input  req, dir, amt,
    output gnt, done, trunc, busy, vol, full, empty
  );
endinterface

// File: rtl/reservoir_sched.sv
// Round-robin scheduler sharing one saturating volume counter among NREQ
// requesters; steps the volume one unit per cycle per granted operation.
module reservoir_sched #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CAP   = 15000,
  parameter int unsigned CBITS = 14,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  reservoir_sched_if.slave  bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] CAP_V = CBITS'(CAP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    last;
  logic             op_dir;
  logic [AW-1:0]    rem;
  logic [CBITS-1:0] vol;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic             trunc;
  logic             busy;

  logic [IW-1:0]    win;
  logic             found;
  int unsigned      idx;

  // Round-robin search for the next requester, starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = last;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Scheduler FSM: grant in IDLE, step volume in RUN, report in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= IW'(NREQ - 1);
      op_dir <= 1'b0;
      rem    <= '0;
      vol    <= '0;
      gnt    <= '0;
      done   <= '0;
      trunc  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      gnt   <= '0;
      done  <= '0;
      trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            op_dir <= bus.dir[win];
            rem    <= bus.amt[32'(win)*AW +: AW];
            gnt    <= NREQ'(1) << win;
            last   <= win;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (rem == '0) begin
            done  <= NREQ'(1) << last;
            state <= DONE;
          end else if ((op_dir && vol == CAP_V) || (!op_dir && vol == '0)) begin
            done  <= NREQ'(1) << last;
            trunc <= 1'b1;
            state <= DONE;
          end else begin
            vol <= op_dir ? vol + CBITS'(1) : vol - CBITS'(1);
            rem <= rem - AW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt;
  assign bus.done  = done;
  assign bus.trunc = trunc;
  assign bus.busy  = busy;
  assign bus.vol   = vol;
  assign bus.full  = (vol == CAP_V);
  assign bus.empty = (vol == '0);

endmodule

// File: doc/reservoir_sched.md
# reservoir_sched

Round-robin scheduler that shares one saturating volume counter (the reservoir, 0..CAP) among NREQ requesters. Each requester asks to load (fill) or store (drain) a number of units. The block grants one operation at a time and steps the volume by one unit per cycle. It reports completion, and flags an operation as truncated when the volume hits a bound (full on load, empty on store). It sits between the client request logic and the load/store volume datapath, and owns that datapath's state.

## Interface
- NREQ, 2: number of requesters (2..8).
- CAP, 15000: reservoir capacity; vol saturates at CAP.
- CBITS, 14: vol width; must satisfy 2^CBITS > CAP.
- AW, 8: per-request amount width.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; hold until gnt.
- dir  in  NREQ  per requester: 1 = load (vol up), 0 = store (vol down); sampled at grant.
- amt  in  NREQ*AW  per-requester unit count, requester i at bits [i*AW +: AW]; sampled at grant.
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted.
- done  out  NREQ  one-hot, one-cycle pulse: granted operation finished.
- trunc  out  1  valid with done: operation ended early at a bound.
- busy  out  1  high in RUN and DONE states.
- vol  out  CBITS  current reservoir volume (registered).
- full  out  1  vol == CAP (combinational from vol).
- empty  out  1  vol == 0 (combinational from vol).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if any req bit is set, pick winner w by round robin (search starts at last+1 mod NREQ). Latch op_dir=dir[w] and rem=amt[w], pulse gnt[w], set last=w, go to RUN. No req: stay in IDLE.
- RUN, at each edge, evaluated in order:
  - rem == 0: go to DONE with trunc=0.
  - op_dir=1 and vol==CAP, or op_dir=0 and vol==0: go to DONE with trunc=1.
  - Otherwise: vol ±1, rem −1, stay in RUN.
- DONE: done[w] and trunc are high for this single cycle. Next edge goes to IDLE.
- Arithmetic: vol never leaves 0..CAP. rem is AW bits and never underflows.
- amt=0: granted normally, no vol change, done with trunc=0.
- req for a requester already being served is ignored until the FSM returns to IDLE. req dropped before grant is a legal withdrawal.
- Reset:
  - vol=0, state IDLE, gnt=0, done=0, trunc=0, busy=0, full=0, empty=1.
  - last=NREQ−1, so requester 0 has first priority.
  - Reset during RUN or DONE aborts the operation: no done pulse, vol=0.
- Invariants: gnt and done are each one-hot or zero. At most one operation is in flight. A req held continuously is granted within NREQ operations.

## Timing
- Req sampled high in IDLE at edge E0 produces the following sequence:
  - gnt high in cycle E0..E1.
  - First vol change at E1.
  - With no truncation, k = amt units change vol at E1..Ek.
  - State DONE at Ek+1; done high in cycle Ek+1..Ek+2.
  - IDLE at Ek+2.
  - Earliest next grant at Ek+2 edge + 1, i.e. gnt high after Ek+3.
- Truncated operation, bound reached after j < k steps: done is set at Ej+1.
- Grant-to-done latency is amt+1 cycles without truncation.
- One idle cycle separates back-to-back operations.
- full and empty follow vol with zero additional latency.

## Test plan
- Reset, then load by req0 with amt=5 -> gnt[0] after E0, vol 1..5 at E1..E5, done[0] at E6 with trunc=0, vol=5, empty=0.
- CAP=10 override, vol=8, req1 load amt=5 -> vol reaches 10 at E2, done[1] at E3 with trunc=1, full=1.
- req0 and req1 both held, each store amt=1 from vol=5 -> grants alternate 0,1,0,1 and vol decrements once per operation. Starving either requester is a failure.
- vol=0, store amt=3 -> immediate trunc: done at E1 with trunc=1, vol stays 0, empty=1.
- amt=0 load -> gnt then done one cycle later with trunc=0, vol unchanged.
- rst asserted mid-RUN (vol=7, rem=4) -> next cycle vol=0, IDLE, no done pulse, busy=0, empty=1.
